// File: rtl/audio_dac_serializer_if.sv
// Audio-out sample handshake between the tone mixer (master) and the DAC serializer (slave).
interface audio_dac_serializer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] left_channel_audio_out;
  logic [DATA_WIDTH-1:0] right_channel_audio_out;
  logic                  write_audio_out;
  logic                  audio_out_allowed;
  logic [LVL_W-1:0]      fifo_level;

  modport master (
    output left_channel_audio_out,
    output right_channel_audio_out,
    output write_audio_out,
    input  audio_out_allowed,
    input  fifo_level
  );

  modport slave (
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    input  write_audio_out,
    output audio_out_allowed,
    output fifo_level
  );
endinterface

// File: rtl/audio_dac_serializer.sv
// Buffers stereo pairs in a small FIFO and plays them to a WM8731 DAC as I2S,
// generating BCLK and DACLRCK as clock master.
module audio_dac_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BCLK_HALF  = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  audio_dac_serializer_if.slave  aud,
  output logic                   underflow,
  output logic                   AUD_BCLK,
  output logic                   AUD_DACLRCK,
  output logic                   AUD_DACDAT
);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W      = PTR_W + 1;
  localparam int unsigned FRAME_BITS = 2 * DATA_WIDTH;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } pair_t;

  pair_t                 mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  lrck_q, lrck_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic                  uf_q, uf_d;

  logic allowed_c, push_c, pop_c, div_wrap_c, bclk_fall_c;

  assign allowed_c = (level_q != LVL_W'(FIFO_DEPTH));
  assign push_c    = aud.write_audio_out && allowed_c;

  // Next-state logic: divider, bit framing, frame-start pop and FIFO bookkeeping.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    div_d     = div_q;
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    sr_d      = sr_q;
    uf_d      = uf_q;
    pop_c     = 1'b0;

    div_wrap_c  = (div_q == DIV_W'(BCLK_HALF - 1));
    bclk_fall_c = div_wrap_c && bclk_q;

    div_d = div_wrap_c ? '0 : div_q + DIV_W'(1);
    if (div_wrap_c) bclk_d = ~bclk_q;

    if (bclk_fall_c) begin
      bit_cnt_d = (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
      lrck_d    = (bit_cnt_d >= BIT_W'(DATA_WIDTH));
      // Loading one bit after the LRCK edge gives the I2S one-bit delay.
      if (bit_cnt_d == BIT_W'(1)) begin
        if (level_q != '0) begin
          pop_c    = 1'b1;
          sr_d     = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
          sr_d = '0;
          uf_d = 1'b1;
        end
      end else begin
        sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
      end
    end

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      div_q     <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      lrck_q    <= 1'b0;
      sr_q      <= '0;
      uf_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrck_q    <= lrck_d;
      sr_q      <= sr_d;
      uf_q      <= uf_d;
    end
  end

  // Sample storage needs no reset; entries are only read after being written.
  always_ff @(posedge CLOCK_50) begin
    if (push_c) mem_q[wr_ptr_q] <= pair_t'({aud.left_channel_audio_out, aud.right_channel_audio_out});
  end

  assign aud.audio_out_allowed = allowed_c;
  assign aud.fifo_level        = level_q;
  assign underflow             = uf_q;
  assign AUD_BCLK              = bclk_q;
  assign AUD_DACLRCK           = lrck_q;
  assign AUD_DACDAT            = sr_q[FRAME_BITS-1];
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Scoreboard bench: a cycle-level reference queues expected I2S words; a pin monitor
// reassembles words from DACDAT at BCLK rises and compares them.
module tb_audio_dac_serializer;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned HALF  = 8;
  localparam int unsigned FRAME = 2 * DW * 2 * HALF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic underflow, bclk, lrck, dat;

  audio_dac_serializer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) aud_if ();

  audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BCLK_HALF(HALF)) dut (
    .CLOCK_50    (clk),
    .resetn      (rst_n),
    .aud         (aud_if),
    .underflow   (underflow),
    .AUD_BCLK    (bclk),
    .AUD_DACLRCK (lrck),
    .AUD_DACDAT  (dat)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycles since reset release; frame starts at the BCLK fall into bit 1.
  int unsigned cyc;
  int unsigned m_lvl;
  bit          m_uf;
  bit          push_ok, pop_ok, start;
  logic [63:0] pend_q[$];
  logic [63:0] word_q[$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cyc = 0; m_lvl = 0; m_uf = 1'b0;
      pend_q.delete();
      word_q.delete();
    end else begin
      cyc++;
      start   = ((cyc % FRAME) == 2 * HALF);
      push_ok = aud_if.write_audio_out && (m_lvl != DEPTH);
      pop_ok  = start && (m_lvl != 0);
      if (pop_ok) word_q.push_back(pend_q.pop_front());
      else if (start) begin
        word_q.push_back(64'd0);
        m_uf = 1'b1;
      end
      if (push_ok) pend_q.push_back({aud_if.left_channel_audio_out, aud_if.right_channel_audio_out});
      if (push_ok && !pop_ok) m_lvl++;
      if (pop_ok && !push_ok) m_lvl--;
    end
  end

  // Pin monitor: status every cycle, and bit/word checks at each BCLK rise.
  int unsigned rise_k, nbits, b;
  logic [63:0] wacc, w_exp;
  logic        prev_bclk, prev_dat;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rise_k = 0; nbits = 0; wacc = '0; prev_bclk = 1'b0; prev_dat = 1'b0;
    end else begin
      check_eq("level", 64'(aud_if.fifo_level), 64'(m_lvl));
      check_eq("allowed", 64'(aud_if.audio_out_allowed), 64'(m_lvl != DEPTH));
      check_eq("underflow", 64'(underflow), 64'(m_uf));
      if (bclk && !prev_bclk) begin
        b = rise_k % (2 * DW);
        check_eq("bclk_phase", 64'(cyc % (2 * HALF)), 64'(HALF));
        check_eq("dat_stable", 64'(dat), 64'(prev_dat));
        check_eq("lrck", 64'(lrck), 64'(b >= DW));
        if (b == 1) begin
          wacc  = {63'd0, dat};
          nbits = 1;
        end else if (nbits > 0) begin
          wacc  = {wacc[62:0], dat};
          nbits++;
        end
        if (b == 0 && nbits == 2 * DW) begin
          check_eq("word_avail", 64'(word_q.size() != 0), 64'd1);
          if (word_q.size() != 0) begin
            w_exp = word_q.pop_front();
            check_eq("word", wacc, w_exp);
          end
          nbits = 0;
        end
        rise_k++;
      end
      prev_bclk = bclk;
      prev_dat  = dat;
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_bclk"}, 64'(bclk), 64'd0);
    check_eq({tag, "_lrck"}, 64'(lrck), 64'd0);
    check_eq({tag, "_dat"}, 64'(dat), 64'd0);
    check_eq({tag, "_level"}, 64'(aud_if.fifo_level), 64'd0);
    check_eq({tag, "_allowed"}, 64'(aud_if.audio_out_allowed), 64'd1);
    check_eq({tag, "_uf"}, 64'(underflow), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    aud_if.left_channel_audio_out  = l;
    aud_if.right_channel_audio_out = r;
    aud_if.write_audio_out         = 1'b1;
    @(negedge clk);
    aud_if.write_audio_out         = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    aud_if.left_channel_audio_out  = '0;
    aud_if.right_channel_audio_out = '0;
    aud_if.write_audio_out         = 1'b0;

    // Reset values and first BCLK rise BCLK_HALF cycles after release.
    do_reset();
    idle(7);
    check_eq("bclk_first_lo", 64'(bclk), 64'd0);
    idle(1);
    check_eq("bclk_first_hi", 64'(bclk), 64'd1);

    // Single pair then idle: pair plays, following empty frame sets underflow.
    push(32'hA5A5_0000, 32'h0000_5A5A);
    check_eq("pair_level", 64'(aud_if.fifo_level), 64'd1);
    idle(2 * FRAME + 64);
    check_eq("pair_uf", 64'(underflow), 64'd1);

    // Starvation: underflow rises exactly at the first frame start.
    do_reset();
    idle(15);
    check_eq("starve_uf_pre", 64'(underflow), 64'd0);
    idle(1);
    check_eq("starve_uf_set", 64'(underflow), 64'd1);
    idle(2 * FRAME);
    check_eq("starve_uf_hold", 64'(underflow), 64'd1);

    // Fill: nine back-to-back pushes, the ninth is dropped.
    do_reset();
    for (int i = 1; i <= 8; i++) push(32'(i), 32'(i) ^ 32'hFFFF_0000);
    check_eq("fill_level", 64'(aud_if.fifo_level), 64'd8);
    check_eq("fill_allowed", 64'(aud_if.audio_out_allowed), 64'd0);
    push(32'd9, 32'hFFFF_0009);
    check_eq("fill_drop", 64'(aud_if.fifo_level), 64'd8);
    idle(9 * FRAME + 100);

    // Continuous writes while full: pop-cycle writes dropped, next accepted.
    do_reset();
    aud_if.write_audio_out = 1'b1;
    for (int c = 0; c < 4 * int'(FRAME); c++) begin
      aud_if.left_channel_audio_out  = 32'(c) + 32'h1000_0000;
      aud_if.right_channel_audio_out = ~32'(c);
      @(negedge clk);
    end
    aud_if.write_audio_out = 1'b0;
    idle(9 * FRAME + 100);

    // Reset mid-frame at bit 40 with three pairs still queued.
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hC0DE_0000 + 32'(i), 32'h0BAD_0000 + 32'(i));
    for (int t = 0; t < 3000 && cyc != 40 * 2 * HALF; t++) @(negedge clk);
    check_eq("mid_reach", 64'(cyc), 64'(40 * 2 * HALF));
    check_eq("mid_level", 64'(aud_if.fifo_level), 64'd3);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    @(negedge clk); #2 rst_n = 1'b1;
    idle(2 * FRAME + 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Sink end of the audio-out sample handshake. The tone mixer presents a stereo pair with `write_audio_out`; this block accepts it only while `audio_out_allowed` is high and buffers it in a small FIFO. It then serializes each pair onto the WM8731 DAC pins in I2S format, acting as bit-clock and LR-clock master. It sits between the piano sound path and the codec pins, in place of the DAC half of the generic audio controller.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: bits per channel sample.
- `FIFO_DEPTH`, default 8: number of stereo pairs buffered. Must be a power of two, ≥ 2.
- `BCLK_HALF`, default 8: `CLOCK_50` cycles per BCLK half-period. The defaults give 3.125 MHz BCLK and a 48.83 kHz frame.

**Ports**
- `CLOCK_50`, in, 1: the only clock. All logic is on its rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `left_channel_audio_out`, in, DATA_WIDTH: left sample, two's complement.
- `right_channel_audio_out`, in, DATA_WIDTH: right sample, two's complement.
- `write_audio_out`, in, 1: push request for one stereo pair.
- `audio_out_allowed`, out, 1: FIFO not full.
- `fifo_level`, out, log2(FIFO_DEPTH)+1: number of stereo pairs held.
- `underflow`, out, 1: sticky flag, set when a frame starts with the FIFO empty.
- `AUD_BCLK`, out, 1: bit clock to the codec.
- `AUD_DACLRCK`, out, 1: LR clock. Low = left channel, high = right channel.
- `AUD_DACDAT`, out, 1: serial DAC data.

## Operation

**FIFO**
- Circular buffer holding 2×DATA_WIDTH-bit entries.
- Push occurs when `write_audio_out && audio_out_allowed`. A write while full is ignored; no error flag is raised.
- `audio_out_allowed = (fifo_level != FIFO_DEPTH)`, combinational from the registered level.
- A push and a pop in the same cycle leave the level unchanged. Both pointers advance.
- A push and a pop are both legal when full; the pop frees space, but the push is still gated by the pre-edge `audio_out_allowed` (0), so it is dropped.
- Read and write pointers wrap modulo FIFO_DEPTH.

**Clock generation**
- Divider counter runs 0..BCLK_HALF-1. `AUD_BCLK` toggles each time the counter wraps.
- Bit counter `bit_cnt` runs 0..2·DATA_WIDTH-1. It advances on every BCLK falling edge, i.e. the cycle `AUD_BCLK` goes 1→0, and wraps to 0.
- `AUD_DACLRCK` is low for `bit_cnt` 0..DATA_WIDTH-1 and high for the rest. It is registered and changes on the same falling edge as `bit_cnt`.

**Serializer**
- 2×DATA_WIDTH shift register.
- On the falling edge where `bit_cnt` becomes 1:
  - FIFO not empty: pop the head and load `{left, right}`.
  - FIFO empty: load zero and set `underflow`.
- On every other falling edge, shift left by one.
- `AUD_DACDAT` equals the shift register MSB. This gives the standard I2S one-bit delay after each LRCK edge. The right-channel LSB appears during `bit_cnt` 0 of the following frame.
- `underflow` clears only on reset.

## Timing

- **Reset values:** `AUD_BCLK`=0, `AUD_DACLRCK`=0, `AUD_DACDAT`=0, `fifo_level`=0, `audio_out_allowed`=1, `underflow`=0. Both pointers, the shift register, the divider and `bit_cnt` are 0.
- **Reset mid-frame:** all state clears immediately, asynchronously. Buffered samples are discarded. The first BCLK rising edge occurs BCLK_HALF cycles after `resetn` deasserts.
- **Push latency:** `fifo_level` increments in the cycle after an accepted push. `audio_out_allowed` falls in the same cycle the level reaches FIFO_DEPTH.
- **Pop:** happens in the CLOCK_50 cycle of the BCLK falling edge into `bit_cnt`=1. The level decrements in that same update.
- **Frame period:** 2·DATA_WIDTH·2·BCLK_HALF `CLOCK_50` cycles, which is 1024 at defaults.
- **Output changes:** `AUD_DACDAT` and `AUD_DACLRCK` change only on BCLK falling edges and are stable across BCLK rising edges. The codec samples on the rising edge.

## Test plan

- **Reset:** hold `resetn`=0 → all outputs at their reset values. Release → first BCLK rise after 8 cycles; BCLK period 16 cycles; LRCK period 1024 cycles.
- **Single pair:** push L=0xA5A50000, R=0x00005A5A, then idle → bits on DACDAT from `bit_cnt` 1 through `bit_cnt` 0 of the next frame read back as 0xA5A50000 then 0x00005A5A. `fifo_level` goes 1→0 at the pop; `underflow` stays 0 during this frame and is set at the start of the following (empty) frame.
- **Fill:** 9 back-to-back pushes with values 1..9 → `fifo_level`=8 and `audio_out_allowed`=0 after push 8. Push 9 is dropped. Frames then play 1..8 in order.
- **Starvation:** push nothing after reset → DACDAT stays 0, and `underflow`=1 from the first `bit_cnt`=1 edge onward.
- **Simultaneous events at full:** keep the FIFO full and assert `write_audio_out` continuously → at each pop cycle the write is dropped. One cycle later `audio_out_allowed`=1 and the next write is accepted. `fifo_level` never exceeds 8.
- **Reset mid-frame:** assert `resetn`=0 at `bit_cnt`=40 with 3 pairs queued → outputs clear within the same cycle, `fifo_level`=0, and the next frame plays zeros.
